udp_tx: RTL and testbench
=========================

# udp_tx

Transmit-side UDP framer. It accepts an application payload stream with its byte length given up front, and emits a 16-bit stream to the IP transmit layer. That stream carries the 8-byte UDP header (fixed source/destination ports, computed length, checksum 0, which is legal over IPv4) followed by the payload. It sits between the application and the IP tx block and is the counterpart of the UDP receive path.

## Interface

**Parameters**

- DATA_W, 16: datapath width; only 16 is supported.
- LEN_W, $clog2(DATA_W/8): width of the byte-count field per beat.
- PORT_W, 16: port width.
- SRC_PORT, 16'd18070: source port inserted in the header.
- DST_PORT, 16'd18070: destination port inserted in the header.
- PLEN_W, 16: payload length width.

**Ports**

- clk  in  1  clock.
- nreset  in  1  reset, synchronous, active-low.
- valid_i  in  1  application beat valid.
- start_i  in  1  first beat of a payload; qualified by valid_i.
- data_i  in  DATA_W  payload; first wire byte in [7:0].
- plen_i  in  PLEN_W  payload length in bytes; sampled with valid_i & start_i in IDLE.
- cancel_i  in  1  abort the current frame.
- ready_o  out  1  payload beat consumed when valid_i & ready_o.
- valid_o  out  1  beat to IP layer valid.
- start_o  out  1  first header word.
- last_o  out  1  final beat of the UDP datagram.
- data_o  out  DATA_W  header/payload word; first wire byte in [7:0].
- len_o  out  LEN_W  0 = both bytes valid, 1 = only [7:0] valid.
- ready_i  in  1  IP layer accepts when valid_o & ready_i.
- cancel_o  out  1  abort indication to IP layer.

## Operation

- **State machine:** one-hot over IDLE, HEAD, DATA, DROP. Reset state is IDLE.
- **IDLE**
  - ready_o=0.
  - On valid_i & start_i, register plen_q=plen_i and udp_len_q=plen_i+8 (16-bit).
  - If plen_i > 16'hFFF7, go to DROP. Otherwise go to HEAD with hcnt=0.
  - The start beat itself is not consumed in IDLE.
- **HEAD**
  - valid_o=1, ready_o=0.
  - Header words are built from registers and constants; multi-byte fields are big-endian on the wire:
    - hcnt 0: {SRC_PORT[7:0], SRC_PORT[15:8]}
    - hcnt 1: {DST_PORT[7:0], DST_PORT[15:8]}
    - hcnt 2: {udp_len_q[7:0], udp_len_q[15:8]}
    - hcnt 3: 16'h0000
  - start_o=1 only for hcnt 0. len_o=0.
  - hcnt advances on ready_i.
  - After word 3 is accepted: go to DATA with rem_q=plen_q, or to IDLE if plen_q==0.
  - If plen_q==0, last_o=1 on word 3.
- **DATA**
  - Combinational passthrough: valid_o=valid_i, ready_o=ready_i, data_o=data_i, start_o=0.
  - Each handshake does rem_q -= min(rem_q,2).
  - last_o=(rem_q<=2). len_o=(rem_q==1).
  - After the last handshake, go to IDLE.
  - The upstream start_i is ignored in DATA.
- **DROP** (oversize request)
  - ready_o=1, valid_o=0.
  - Consumes payload beats, decrementing rem_q=plen_q as in DATA.
  - Returns to IDLE after the beat with rem_q<=2.
- **Cancel**
  - cancel_i in HEAD, DATA or DROP causes the next state to be IDLE. Cancel has priority over every other transition.
  - cancel_o=cancel_i & ~idle, combinational, so it is only raised when a frame is in progress.
  - The beat in the cancel cycle is not a valid transfer: valid_o and ready_o are forced to 0.
  - cancel_i in IDLE has no effect.
- **Arithmetic:** udp_len and rem_q are 16-bit. The oversize check guarantees that plen+8 never wraps.

## Timing

- **Reset values:** valid_o=0, start_o=0, last_o=0, ready_o=0, cancel_o=0, len_o=0, data_o=0 (in IDLE data_o is driven 0).
- **Header latency:**
  - First header word is valid on the cycle after start is sampled.
  - With ready_i held high, the header occupies exactly 4 cycles.
  - ready_o rises on the 5th cycle after sampling.
- **Payload latency:** 0 cycles, combinational, in DATA. There is no internal buffering.
- **Stalls:** ready_i low holds hcnt and all outputs stable. Values must not change while valid_o & ~ready_i.
- **Back-to-back frames:** an IDLE cycle follows every frame, so a new start is sampled at the earliest 1 cycle after last.
- **Mid-frame reset:** nreset low takes effect in the next cycle. The block returns to IDLE, outputs are at reset values, and no cancel_o is generated.

## Test plan

- **Normal frame:** plen_i=5, payload bytes 01..05, ready_i=1.
  - Output: 0x9646, 0x9646, 0x0D00, 0x0000, then 0x0201, 0x0403, then 0x??05 with len_o=1 and last_o=1.
  - start_o is set only on the first word.
- **Zero payload:** plen_i=0.
  - Exactly 4 header words; length word 0x0800; last_o on the 4th word; ready_o never asserted.
- **Backpressure:** plen_i=4, ready_i toggling 1/0 every cycle.
  - Same word sequence as without stalls; outputs stable during stalls; 6 handshakes total.
- **Oversize:** plen_i=16'hFFF8.
  - No valid_o. 32764 input beats consumed with ready_o=1. Return to IDLE; a following plen_i=2 frame is emitted correctly.
- **Cancel:** cancel_i on the 2nd payload beat of a plen_i=10 frame.
  - cancel_o=1 that cycle, valid_o=0, IDLE next cycle, next frame unaffected.
- **Reset mid-HEAD:** nreset low on header word 2.
  - All outputs at reset values the next cycle; state IDLE.

Source files
------------

// File: rtl/udp_tx.sv
// UDP transmit framer: prepends the 8-byte UDP header (fixed ports, computed
// length, zero checksum) to an application payload and streams it to IP tx.
module udp_tx #(
    parameter int                 DATA_W   = 16,
    parameter int                 LEN_W    = $clog2(DATA_W/8),
    parameter int                 PORT_W   = 16,
    parameter logic [PORT_W-1:0]  SRC_PORT = 16'd18070,
    parameter logic [PORT_W-1:0]  DST_PORT = 16'd18070,
    parameter int                 PLEN_W   = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              valid_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [PLEN_W-1:0] plen_i,
    input  logic              cancel_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic              start_o,
    output logic              last_o,
    output logic [DATA_W-1:0] data_o,
    output logic [LEN_W-1:0]  len_o,
    input  logic              ready_i,
    output logic              cancel_o
);

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        HEAD = 4'b0010,
        DATA = 4'b0100,
        DROP = 4'b1000
    } state_t;

    // Largest payload whose UDP length (payload + 8) still fits in 16 bits.
    localparam logic [PLEN_W-1:0] MAX_PLEN = PLEN_W'(16'hFFF7);
    localparam logic [PLEN_W-1:0] TWO      = PLEN_W'(2);

    state_t              state_q, state_d;
    logic [1:0]          hcnt_q, hcnt_d;
    logic [PLEN_W-1:0]   plen_q, plen_d;
    logic [PLEN_W-1:0]   udp_len_q, udp_len_d;
    logic [PLEN_W-1:0]   rem_q, rem_d;
    logic                rem_last;
    logic [PLEN_W-1:0]   rem_dec;

    // A beat carries at most two bytes; the final beat may carry one.
    assign rem_last = (rem_q <= TWO);
    assign rem_dec  = rem_last ? '0 : rem_q - TWO;

    // Next-state and output decode; cancel overrides every transition.
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        plen_d    = plen_q;
        udp_len_d = udp_len_q;
        rem_d     = rem_q;
        ready_o   = 1'b0;
        valid_o   = 1'b0;
        start_o   = 1'b0;
        last_o    = 1'b0;
        data_o    = '0;
        len_o     = '0;
        cancel_o  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Start beat is only inspected here; DATA/DROP consume it.
                if (valid_i && start_i) begin
                    plen_d    = plen_i;
                    udp_len_d = plen_i + PLEN_W'(8);
                    rem_d     = plen_i;
                    hcnt_d    = 2'd0;
                    state_d   = (plen_i > MAX_PLEN) ? DROP : HEAD;
                end
            end
            HEAD: begin
                valid_o = 1'b1;
                start_o = (hcnt_q == 2'd0);
                last_o  = (hcnt_q == 2'd3) && (plen_q == '0);
                // Header fields are big-endian; first wire byte sits in [7:0].
                unique case (hcnt_q)
                    2'd0:    data_o = DATA_W'({SRC_PORT[7:0], SRC_PORT[15:8]});
                    2'd1:    data_o = DATA_W'({DST_PORT[7:0], DST_PORT[15:8]});
                    2'd2:    data_o = DATA_W'({udp_len_q[7:0], udp_len_q[15:8]});
                    default: data_o = '0;
                endcase
                if (ready_i) begin
                    if (hcnt_q == 2'd3) begin
                        rem_d   = plen_q;
                        state_d = (plen_q == '0) ? IDLE : DATA;
                    end else begin
                        hcnt_d = hcnt_q + 2'd1;
                    end
                end
            end
            DATA: begin
                valid_o = valid_i;
                ready_o = ready_i;
                data_o  = data_i;
                last_o  = rem_last;
                len_o   = LEN_W'(rem_q == PLEN_W'(1));
                if (valid_i && ready_i) begin
                    rem_d = rem_dec;
                    if (rem_last) state_d = IDLE;
                end
            end
            DROP: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    rem_d = rem_dec;
                    if (rem_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cancel_i && (state_q != IDLE)) begin
            state_d  = IDLE;
            valid_o  = 1'b0;
            ready_o  = 1'b0;
            cancel_o = 1'b1;
        end
    end

    // State and frame registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q   <= IDLE;
            hcnt_q    <= 2'd0;
            plen_q    <= '0;
            udp_len_q <= '0;
            rem_q     <= '0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            plen_q    <= plen_d;
            udp_len_q <= udp_len_d;
            rem_q     <= rem_d;
        end
    end

endmodule

// File: tb/tb_udp_tx.sv
module tb_udp_tx;

    logic        clk = 1'b0;
    logic        nreset;
    logic        valid_i, start_i, cancel_i, ready_i;
    logic [15:0] data_i, plen_i;
    logic        ready_o, valid_o, start_o, last_o, cancel_o;
    logic [15:0] data_o;
    logic [0:0]  len_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] d;
        logic        s;
        logic        l;
        logic        n;
    } ow_t;

    udp_tx dut (
        .clk(clk), .nreset(nreset),
        .valid_i(valid_i), .start_i(start_i), .data_i(data_i), .plen_i(plen_i),
        .cancel_i(cancel_i), .ready_o(ready_o), .valid_o(valid_o), .start_o(start_o),
        .last_o(last_o), .data_o(data_o), .len_o(len_o), .ready_i(ready_i),
        .cancel_o(cancel_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_valid"},  {31'd0, valid_o},  32'd0);
        chk({tag, "_start"},  {31'd0, start_o},  32'd0);
        chk({tag, "_last"},   {31'd0, last_o},   32'd0);
        chk({tag, "_ready"},  {31'd0, ready_o},  32'd0);
        chk({tag, "_cancel"}, {31'd0, cancel_o}, 32'd0);
        chk({tag, "_len"},    {31'd0, len_o},    32'd0);
        chk({tag, "_data"},   {16'd0, data_o},   32'd0);
    endtask

    // mode: 0 ready always, 1 ready toggling, 2 ready random.
    // cancel_at: payload beat index on which to cancel, or -1.
    task automatic run_frame(input int plen, input int mode, input int cancel_at);
        logic [7:0]  wb[$];
        logic [7:0]  pb[$];
        logic [15:0] bdata[$];
        ow_t         expq[$];
        ow_t         e;
        logic [15:0] ul;
        logic [7:0]  b;
        logic [18:0] stv;
        logic        stl, cur_v;
        int          nb, k, hs, cyc, nexp;
        bit          cancelled;

        // Reference model: the datagram as a byte stream, then packed to words.
        ul = 16'(plen + 8);
        wb = {8'h46, 8'h96, 8'h46, 8'h96, ul[15:8], ul[7:0], 8'h00, 8'h00};
        for (int i = 0; i < plen; i++) begin
            b = 8'($urandom);
            wb.push_back(b);
            pb.push_back(b);
        end
        for (int i = 0; i < wb.size(); i += 2) begin
            e.n = (i + 1 >= wb.size());
            e.d = e.n ? {8'h00, wb[i]} : {wb[i+1], wb[i]};
            e.s = (i == 0);
            e.l = (i + 2 >= wb.size());
            expq.push_back(e);
        end
        nexp = expq.size();
        for (int i = 0; i < plen; i += 2)
            bdata.push_back({(i + 1 < plen) ? pb[i+1] : 8'($urandom), pb[i]});
        nb = bdata.size();

        k = 0; hs = 0; cyc = 0; stl = 0; stv = '0; cur_v = 0; cancelled = 0;
        while (!(expq.size() == 0 && k >= nb)) begin
            @(negedge clk);
            if (cyc >= 4000) begin
                chk("frame_timeout", cyc, 0);
                break;
            end
            cancel_i = 1'b0;
            plen_i   = 16'(plen);
            if (plen == 0) begin
                valid_i = (cyc == 0);
                start_i = (cyc == 0);
                data_i  = 16'h0;
            end else if (k < nb) begin
                if (!cur_v) cur_v = (k == 0) || ($urandom_range(3) != 0);
                valid_i = cur_v;
                start_i = (k == 0);
                data_i  = bdata[k];
            end else begin
                valid_i = 1'b0;
                start_i = 1'b0;
            end
            ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(1));
            if (cancel_at >= 0 && hs == 4 + cancel_at) begin
                cancel_i = 1'b1;
                valid_i  = 1'b1;
            end
            #1;
            if (cancel_i) begin
                chk("cancel_o",     {31'd0, cancel_o}, 32'd1);
                chk("cancel_valid", {31'd0, valid_o},  32'd0);
                chk("cancel_ready", {31'd0, ready_o},  32'd0);
                cancelled = 1;
                break;
            end
            chk("no_cancel", {31'd0, cancel_o}, 32'd0);
            if (hs < 4) chk("head_ready", {31'd0, ready_o}, 32'd0);
            if (cyc == 0) chk("idle_valid", {31'd0, valid_o}, 32'd0);
            if (cyc == 1) chk("first_word_lat", {30'd0, valid_o, start_o}, 32'd3);
            if (stl) chk("stall_stable", {13'd0, data_o, start_o, last_o, len_o}, {13'd0, stv});
            if (valid_o && ready_i) begin
                if (expq.size() == 0) begin
                    chk("extra_word", {16'd0, data_o}, 32'hFFFF_FFFF);
                end else begin
                    e = expq.pop_front();
                    chk("word", {13'd0, (e.n ? 8'h00 : data_o[15:8]), data_o[7:0],
                                 start_o, last_o, len_o},
                                {13'd0, e.d, e.s, e.l, e.n});
                    hs++;
                end
            end
            stl = valid_o && !ready_i;
            stv = {data_o, start_o, last_o, len_o};
            if (valid_i && ready_o) begin
                k++;
                cur_v = 0;
            end
            cyc++;
        end
        if (!cancelled) chk("word_count", hs, nexp);
        @(negedge clk);
        valid_i = 1'b0; start_i = 1'b0; cancel_i = 1'b0; ready_i = 1'b1;
        #1;
        chk("post_idle_valid", {31'd0, valid_o}, 32'd0);
        chk("post_idle_ready", {31'd0, ready_o}, 32'd0);
    endtask

    initial begin
        int  n, cyc;
        bit  seen_v;

        nreset = 1'b0; valid_i = 0; start_i = 0; cancel_i = 0; ready_i = 0;
        data_i = '0; plen_i = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outs("reset");
        nreset = 1'b1;

        run_frame(5, 0, -1);
        run_frame(0, 0, -1);
        run_frame(4, 1, -1);
        for (int i = 0; i < 6; i++) run_frame($urandom_range(0, 40), 2, -1);
        run_frame(10, 0, 1);
        run_frame(7, 2, -1);

        // Oversize request: every beat swallowed, nothing emitted.
        @(negedge clk);
        valid_i = 1; start_i = 1; plen_i = 16'hFFF8; data_i = 16'($urandom); ready_i = 1;
        #1;
        chk("drop_idle_ready", {31'd0, ready_o}, 32'd0);
        n = 0; cyc = 0; seen_v = 0;
        while (n < 32764 && cyc < 40000) begin
            @(negedge clk);
            start_i = (n == 0);
            valid_i = 1;
            data_i  = 16'($urandom);
            #1;
            if (valid_o) seen_v = 1;
            if (ready_o) n++;
            cyc++;
        end
        chk("drop_no_valid", {31'd0, seen_v}, 32'd0);
        chk("drop_beats", n, 32764);
        @(negedge clk);
        start_i = 0; valid_i = 1;
        #1;
        chk("drop_back_idle", {31'd0, ready_o}, 32'd0);
        valid_i = 0;
        run_frame(2, 0, -1);

        // Reset during header word 2 (udp_len = 14).
        @(negedge clk);
        valid_i = 1; start_i = 1; plen_i = 16'd6; ready_i = 1;
        @(negedge clk);
        valid_i = 0; start_i = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_word2", {16'd0, data_o}, 32'h0000_0E00);
        nreset = 1'b0;
        @(negedge clk);
        #1;
        chk_reset_outs("midrst");
        nreset = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_idle", {30'd0, valid_o, ready_o}, 32'd0);
        run_frame(3, 2, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
